// File: rtl/row_avg_stream_if.sv
// Stream bundle for row_avg_stream: sample input handshake plus the averaged result bus.
// The slave modport is the averager; the master modport is the source/sink side.
interface row_avg_stream_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 16
) ();
  localparam int unsigned RW = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          in_valid;
  logic [DW-1:0] data;
  logic          in_ready;
  logic          valid;
  logic [DW-1:0] out;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          done;

  modport master (
    output in_valid, data,
    input  in_ready, valid, out, out_row, out_col, done
  );

  modport slave (
    input  in_valid, data,
    output in_ready, valid, out, out_row, out_col, done
  );
endinterface

// File: rtl/row_avg_stream.sv
// Streaming vertical row averager: one COLS-entry line buffer, each result is the mean of a
// sample and the one directly above it, issued one cycle after the lower sample is accepted.
module row_avg_stream #(
  parameter int unsigned DW    = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned ROWS  = 16,
  parameter int unsigned ROUND = 0
) (
  input  logic            clk,
  input  logic            reset,
  row_avg_stream_if.slave bus
);
  localparam int unsigned RW  = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
  localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RCW = $clog2(ROWS);

  localparam logic [1:0] FIRST_ROW = 2'd0;
  localparam logic [1:0] AVG       = 2'd1;
  localparam logic [1:0] DONE      = 2'd2;

  localparam logic [CW-1:0]  ColLast = CW'(COLS - 1);
  localparam logic [RCW-1:0] RowLast = RCW'(ROWS - 1);
  localparam logic [DW:0]    RndInc  = (ROUND != 0) ? (DW+1)'(1) : (DW+1)'(0);

  logic [1:0]     state_q, state_d;
  logic [RCW-1:0] row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic           in_ready_q, in_ready_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic [DW-1:0]  out_q, out_d;
  logic [RW-1:0]  out_row_q, out_row_d;
  logic [CW-1:0]  out_col_q, out_col_d;

  logic [DW-1:0]  linebuf_q [COLS];
  logic           lb_we;
  logic           accept;
  logic           col_end;
  logic           row_end;
  logic [DW-1:0]  above;
  logic [DW-1:0]  avg;

  assign accept  = bus.in_valid && in_ready_q;
  assign col_end = (col_q == ColLast);
  assign row_end = (row_q == RowLast);
  assign above   = linebuf_q[col_q];
  // DW+1-bit sum cannot overflow; dropping the LSB leaves a DW-bit mean.
  assign avg     = DW'(({1'b0, above} + {1'b0, bus.data} + RndInc) >> 1);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    out_d     = out_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    lb_we     = 1'b0;

    unique case (state_q)
      FIRST_ROW: begin
        if (accept) begin
          lb_we = 1'b1;
          if (col_end) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = AVG;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      AVG: begin
        if (accept) begin
          lb_we     = 1'b1;
          valid_d   = 1'b1;
          out_d     = avg;
          out_row_d = RW'(row_q - 1'b1);
          out_col_d = col_q;
          if (col_end && row_end) begin
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = DONE;
          end else if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = FIRST_ROW;
      end
      default: begin
        state_d = FIRST_ROW;
        row_d   = '0;
        col_d   = '0;
      end
    endcase

    in_ready_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FIRST_ROW;
      row_q      <= '0;
      col_q      <= '0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      out_q      <= out_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
    end
  end

  // Read of the old entry above and write of the new sample share one edge.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[col_q] <= bus.data;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.valid    = valid_q;
  assign bus.done     = done_q;
  assign bus.out      = out_q;
  assign bus.out_row  = out_row_q;
  assign bus.out_col  = out_col_q;
endmodule

// File: tb/tb_row_avg_stream.sv
// Bench for row_avg_stream: frame-level reference model for the default build, plus small
// vector tables for the rounding (ROWS=2) and single-column builds.
module tb_row_avg_stream;
  localparam int unsigned DW    = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned ROWS  = 16;
  localparam int unsigned FRAME = ROWS * COLS;
  localparam int          RND   = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  row_avg_stream_if #(.DW(DW), .COLS(COLS), .ROWS(ROWS)) m_if ();
  row_avg_stream_if #(.DW(8), .COLS(8), .ROWS(2)) r0_if ();
  row_avg_stream_if #(.DW(8), .COLS(8), .ROWS(2)) r1_if ();
  row_avg_stream_if #(.DW(8), .COLS(1), .ROWS(4)) c1_if ();

  row_avg_stream #(.DW(DW), .COLS(COLS), .ROWS(ROWS), .ROUND(0)) u_main (
    .clk(clk), .reset(reset), .bus(m_if.slave));
  row_avg_stream #(.DW(8), .COLS(8), .ROWS(2), .ROUND(0)) u_r0 (
    .clk(clk), .reset(reset), .bus(r0_if.slave));
  row_avg_stream #(.DW(8), .COLS(8), .ROWS(2), .ROUND(1)) u_r1 (
    .clk(clk), .reset(reset), .bus(r1_if.slave));
  row_avg_stream #(.DW(8), .COLS(1), .ROWS(4), .ROUND(0)) u_c1 (
    .clk(clk), .reset(reset), .bus(c1_if.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: samples of the current frame in raster order.
  int fr [FRAME];
  int m_k;
  bit e_ready, e_valid, e_done;
  int e_out, e_row, e_col;
  int n_valid, last_out, step_no, done_step;

  task automatic model_reset();
    e_ready = 1'b1; e_valid = 1'b0; e_done = 1'b0;
    e_out = 0; e_row = 0; e_col = 0; m_k = 0;
  endtask

  // One clock of the main DUT: check outputs, present inputs, advance the model.
  task automatic step(input bit v, input int d, input bit rst, output bit acc);
    int dd;
    @(negedge clk);
    step_no++;
    chk("in_ready", int'(m_if.in_ready), int'(e_ready));
    chk("valid", int'(m_if.valid), int'(e_valid));
    chk("done", int'(m_if.done), int'(e_done));
    chk("out", int'(m_if.out), e_out);
    chk("out_row", int'(m_if.out_row), e_row);
    chk("out_col", int'(m_if.out_col), e_col);
    if (m_if.valid) n_valid++;
    if (m_if.done) begin
      last_out  = int'(m_if.out);
      done_step = step_no;
    end
    dd = d & ((1 << DW) - 1);
    reset         = rst;
    m_if.in_valid = v;
    m_if.data     = DW'(dd);
    acc = v && e_ready && !rst;
    if (rst) begin
      model_reset();
    end else begin
      e_valid = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      if (acc) begin
        fr[m_k] = dd;
        if (m_k >= int'(COLS)) begin
          e_valid = 1'b1;
          e_out   = (fr[m_k - COLS] + dd + RND) / 2;
          e_row   = m_k / COLS - 1;
          e_col   = m_k % COLS;
        end
        if (m_k == FRAME - 1) begin
          e_done = 1'b1; e_ready = 1'b0; m_k = 0;
        end else begin
          m_k++;
        end
      end
    end
    @(posedge clk);
  endtask

  // mode 0: in_valid held high; 1: alternate cycles with random gaps; 2: random data and gaps.
  task automatic run_frame(input int mode);
    int  idx;
    int  guard;
    bit  v;
    bit  a;
    int  d;
    idx = 0; guard = 0;
    while (idx < int'(FRAME) && guard < 4000) begin
      v = (mode == 0) ? 1'b1 :
          (mode == 1) ? ((guard % 2 == 0) && ($urandom_range(0, 3) != 0)) :
                        ($urandom_range(0, 2) != 0);
      d = (mode == 2) ? int'($urandom_range(0, 255)) : idx;
      step(v, d, 1'b0, a);
      if (a) idx++;
      guard++;
    end
    if (idx < int'(FRAME)) chk("frame_timeout", idx, FRAME);
    step(1'b0, 0, 1'b0, a);
    step(1'b0, 0, 1'b0, a);
  endtask

  typedef struct {
    bit v;
    int d;
    bit ev;
    int ea;
    int eb;
    int erow;
    int ecol;
    bit edone;
  } vec_t;

  vec_t rv[$];
  vec_t cv[$];
  vec_t e;
  bit   acc;
  int   idx;
  int   first_step;

  initial begin
    // Rounding tables (ROWS=2): ea is the truncating build, eb the rounding build.
    for (int c = 0; c < 8; c++) rv.push_back('{1'b1, 3, 1'b0, 0, 0, 0, 0, 1'b0});
    for (int c = 0; c < 8; c++) rv.push_back('{1'b1, 4, 1'b1, 3, 4, 0, c, c == 7});
    rv.push_back('{1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b0});
    for (int c = 0; c < 8; c++) rv.push_back('{1'b1, 255, 1'b0, 0, 0, 0, 0, 1'b0});
    for (int c = 0; c < 8; c++)
      rv.push_back('{1'b1, (c % 2 == 0) ? 254 : 255, 1'b1, (c % 2 == 0) ? 254 : 255, 255,
                     0, c, c == 7});
    rv.push_back('{1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b0});
    // Single-column build, ROWS=4.
    cv.push_back('{1'b1, 10, 1'b0, 0, 0, 0, 0, 1'b0});
    cv.push_back('{1'b1, 20, 1'b1, 15, 0, 0, 0, 1'b0});
    cv.push_back('{1'b1, 31, 1'b1, 25, 0, 1, 0, 1'b0});
    cv.push_back('{1'b1, 41, 1'b1, 36, 0, 2, 0, 1'b1});
    cv.push_back('{1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b0});

    reset = 1'b1;
    m_if.in_valid = 1'b0;  m_if.data = '0;
    r0_if.in_valid = 1'b0; r0_if.data = '0;
    r1_if.in_valid = 1'b0; r1_if.data = '0;
    c1_if.in_valid = 1'b0; c1_if.data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step_no = 0;

    // Rounding builds driven in lockstep.
    for (int i = 0; i <= rv.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = rv[i-1];
        chk("rnd_valid", int'(r0_if.valid), int'(e.ev));
        chk("rnd_done", int'(r1_if.done), int'(e.edone));
        chk("rnd_ready", int'(r0_if.in_ready), int'(!e.edone));
        if (e.ev) begin
          chk("trunc_out", int'(r0_if.out), e.ea);
          chk("round_out", int'(r1_if.out), e.eb);
          chk("rnd_col", int'(r1_if.out_col), e.ecol);
        end
      end
      if (i < rv.size()) begin
        r0_if.in_valid = rv[i].v; r0_if.data = 8'(rv[i].d);
        r1_if.in_valid = rv[i].v; r1_if.data = 8'(rv[i].d);
      end else begin
        r0_if.in_valid = 1'b0; r1_if.in_valid = 1'b0;
      end
    end

    for (int i = 0; i <= cv.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = cv[i-1];
        chk("c1_valid", int'(c1_if.valid), int'(e.ev));
        chk("c1_done", int'(c1_if.done), int'(e.edone));
        if (e.ev) begin
          chk("c1_out", int'(c1_if.out), e.ea);
          chk("c1_row", int'(c1_if.out_row), e.erow);
          chk("c1_col", int'(c1_if.out_col), e.ecol);
        end
      end
      if (i < cv.size()) begin
        c1_if.in_valid = cv[i].v; c1_if.data = 8'(cv[i].d);
      end else begin
        c1_if.in_valid = 1'b0;
      end
    end

    // Ramp frame, in_valid held high.
    n_valid = 0; last_out = -1;
    run_frame(0);
    chk("ramp_count", n_valid, (ROWS - 1) * COLS);
    chk("ramp_last", last_out, 123);

    // Ramp frame with gaps.
    n_valid = 0; last_out = -1;
    run_frame(1);
    chk("gap_count", n_valid, (ROWS - 1) * COLS);
    chk("gap_last", last_out, 123);

    // Random data with random gaps.
    n_valid = 0;
    run_frame(2);
    chk("rand_count", n_valid, (ROWS - 1) * COLS);

    // Reset mid-frame with in_valid high in the reset cycle.
    for (int i = 0; i < 50; i++) step(1'b1, i, 1'b0, acc);
    step(1'b1, 50, 1'b1, acc);
    step(1'b0, 0, 1'b0, acc);
    n_valid = 0; last_out = -1;
    run_frame(0);
    chk("rst_count", n_valid, (ROWS - 1) * COLS);
    chk("rst_last", last_out, 123);

    // Two back-to-back frames; the sample offered in the DONE cycle is held.
    n_valid = 0; idx = 0; first_step = 0; done_step = 0;
    while (idx < 2 * int'(FRAME) && step_no < 100000) begin
      step(1'b1, idx % FRAME, 1'b0, acc);
      if (acc && idx == 0) first_step = step_no;
      if (acc) idx++;
    end
    step(1'b0, 0, 1'b0, acc);
    step(1'b0, 0, 1'b0, acc);
    chk("b2b_count", n_valid, 2 * (ROWS - 1) * COLS);
    chk("b2b_span", done_step - first_step + 1, 2 * (FRAME + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
